// File: rtl/serial_divisibility_by_n.sv
// Serial divisibility checker: tracks (number mod DIVISOR) one bit at a time, MSB-first.
// Optional LSB-first mode (lsb_first port, mode and weight registers) under SERIAL_DIV_LSB_MODE_EN.
module serial_divisibility_by_n #(
    parameter int DIVISOR = 5,
    parameter int CNT_W   = 8,
    localparam int RW     = ($clog2(DIVISOR) < 1) ? 1 : $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             new_bit,
    input  logic             start,
`ifdef SERIAL_DIV_LSB_MODE_EN
    input  logic             lsb_first,
`endif
    output logic [RW-1:0]    remainder,
    output logic             div_by_n,
    output logic [CNT_W-1:0] bit_count,
    output logic             count_sat
);

    localparam logic [RW:0]      DIV_EXT = (RW+1)'(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [RW-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    rem_base;
    logic [CNT_W-1:0] cnt_base;
    logic [RW:0]      t_msb;
    logic [RW-1:0]    rem_msb;

`ifdef SERIAL_DIV_LSB_MODE_EN
    logic          mode_q, mode_d;
    logic [RW-1:0] wt_q, wt_d;
    logic          mode_eff;
    logic [RW-1:0] wt_base;
    logic [RW:0]   t_lsb;
    logic [RW-1:0] rem_lsb;
    logic [RW:0]   t_wt;
    logic [RW-1:0] wt_next;
`endif

    always_comb begin
        // start folds into the same cycle: prior value is taken as the empty number
        rem_base = start ? '0 : rem_q;
        cnt_base = start ? '0 : cnt_q;

        t_msb   = {rem_base, new_bit};
        rem_msb = (t_msb >= DIV_EXT) ? RW'(t_msb - DIV_EXT) : t_msb[RW-1:0];

        rem_d = rem_q;
        cnt_d = cnt_q;

`ifdef SERIAL_DIV_LSB_MODE_EN
        mode_eff = start ? lsb_first : mode_q;
        wt_base  = start ? RW'(1) : wt_q;

        // both operands are below DIVISOR, so one conditional subtract suffices
        t_lsb   = {1'b0, rem_base} + (new_bit ? {1'b0, wt_base} : '0);
        rem_lsb = (t_lsb >= DIV_EXT) ? RW'(t_lsb - DIV_EXT) : t_lsb[RW-1:0];
        t_wt    = {wt_base, 1'b0};
        wt_next = (t_wt >= DIV_EXT) ? RW'(t_wt - DIV_EXT) : t_wt[RW-1:0];

        mode_d = mode_eff;
        wt_d   = wt_q;
`endif

        if (valid) begin
            cnt_d = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
`ifdef SERIAL_DIV_LSB_MODE_EN
            rem_d = mode_eff ? rem_lsb : rem_msb;
            wt_d  = mode_eff ? wt_next : wt_base;
`else
            rem_d = rem_msb;
`endif
        end else if (start) begin
            rem_d = '0;
            cnt_d = '0;
`ifdef SERIAL_DIV_LSB_MODE_EN
            wt_d  = RW'(1);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef SERIAL_DIV_LSB_MODE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            wt_q   <= RW'(1);
        end else begin
            mode_q <= mode_d;
            wt_q   <= wt_d;
        end
    end
`endif

    assign remainder = rem_q;
    assign div_by_n  = (rem_q == '0);
    assign bit_count = cnt_q;
    assign count_sat = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_serial_divisibility_by_n.sv
// Directed bench for serial_divisibility_by_n with DIVISOR=5, CNT_W=3.
// LSB-first steps are included only when SERIAL_DIV_LSB_MODE_EN is defined.
module tb_serial_divisibility_by_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       new_bit;
    logic       start;
    logic       lsb_first;
    logic [2:0] remainder;
    logic       div_by_n;
    logic [2:0] bit_count;
    logic       count_sat;

    int total = 0;
    int bad   = 0;

    serial_divisibility_by_n #(.DIVISOR(5), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .new_bit   (new_bit),
        .start     (start),
`ifdef SERIAL_DIV_LSB_MODE_EN
        .lsb_first (lsb_first),
`endif
        .remainder (remainder),
        .div_by_n  (div_by_n),
        .bit_count (bit_count),
        .count_sat (count_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int r, input int d, input int c, input int s);
        check({tag, ".rem"}, 32'(remainder), 32'(r));
        check({tag, ".div"}, 32'(div_by_n),  32'(d));
        check({tag, ".cnt"}, 32'(bit_count), 32'(c));
        check({tag, ".sat"}, 32'(count_sat), 32'(s));
    endtask

    task automatic step(input logic v, input logic b, input logic s);
        valid   = v;
        new_bit = b;
        start   = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sat_rem [9] = '{1, 3, 2, 0, 1, 3, 2, 0, 1};
        int sat_cnt [9] = '{1, 2, 3, 4, 5, 6, 7, 7, 7};

        rst = 1'b1; valid = 1'b0; new_bit = 1'b0; start = 1'b0; lsb_first = 1'b0;
        @(posedge clk); #1;
        chk_all("reset", 0, 1, 0, 0);
        rst = 1'b0;

        // MSB-first 1,0,1,0 (value 10)
        step(1, 1, 0); chk_all("msb_b1", 1, 0, 1, 0);
        step(1, 0, 0); chk_all("msb_b2", 2, 0, 2, 0);
        step(1, 1, 0); chk_all("msb_b3", 0, 1, 3, 0);
        step(1, 0, 0); chk_all("msb_b4", 0, 1, 4, 0);

        step(0, 1, 0); chk_all("gap1", 0, 1, 4, 0);
        step(0, 0, 0); chk_all("gap2", 0, 1, 4, 0);

        // start alone empties the number
        step(0, 1, 1); chk_all("start_only", 0, 1, 0, 0);
        step(1, 1, 0); chk_all("pre_b1", 1, 0, 1, 0);
        step(1, 1, 0); chk_all("pre_b2", 3, 0, 2, 0);
        step(1, 1, 1); chk_all("start_valid", 1, 0, 1, 0);

        // nine ones from a fresh start: count saturates at 7, remainder keeps going
        for (int i = 0; i < 9; i++) begin
            step(1, 1, (i == 0));
            chk_all($sformatf("sat_%0d", i), sat_rem[i], (sat_rem[i] == 0) ? 1 : 0,
                    sat_cnt[i], (sat_cnt[i] == 7) ? 1 : 0);
        end
        step(0, 0, 0); chk_all("sat_hold", 1, 0, 7, 1);
        step(0, 0, 1); chk_all("sat_clear", 0, 1, 0, 0);

        // asynchronous reset between edges, mid-number
        step(1, 1, 0); chk_all("mid_b1", 1, 0, 1, 0);
        step(1, 1, 0); chk_all("mid_b2", 3, 0, 2, 0);
        valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 0, 1, 0, 0);
        #1 rst = 1'b0;
        step(1, 0, 0); chk_all("post_rst_b1", 0, 1, 1, 0);
        step(1, 1, 0); chk_all("post_rst_b2", 1, 0, 2, 0);

`ifdef SERIAL_DIV_LSB_MODE_EN
        // LSB-first 1,1,1,1 -> 3, 7, 15
        lsb_first = 1'b1;
        step(0, 0, 1); chk_all("lsb_start", 0, 1, 0, 0);
        lsb_first = 1'b0;
        step(1, 1, 0); chk_all("lsb_b1", 1, 0, 1, 0);
        step(1, 1, 0); chk_all("lsb_b2", 3, 0, 2, 0);
        step(1, 1, 0); chk_all("lsb_b3", 2, 0, 3, 0);
        step(1, 1, 0); chk_all("lsb_b4", 0, 1, 4, 0);
        // lsb_first was dropped without start: still LSB-first, value 31
        step(1, 1, 0); chk_all("lsb_hold_b5", 1, 0, 5, 0);
        step(1, 0, 0); chk_all("lsb_hold_b6", 1, 0, 6, 0);
        // start+valid in LSB mode: weight must become 2
        lsb_first = 1'b1;
        step(1, 1, 1); chk_all("lsb_sv_b1", 1, 0, 1, 0);
        step(1, 1, 0); chk_all("lsb_sv_b2", 3, 0, 2, 0);
        // reset returns to MSB-first even with lsb_first held high
        rst = 1'b1;
        #1 chk_all("lsb_rst", 0, 1, 0, 0);
        rst = 1'b0;
        step(1, 1, 0); chk_all("rst_mode_b1", 1, 0, 1, 0);
        step(1, 0, 0); chk_all("rst_mode_b2", 2, 0, 2, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_divisibility_by_n.md
SERIAL_DIVISIBILITY_BY_N -- requirements
Module: serial_divisibility_by_n

Interface
REQ-001 The block SHALL have parameter DIVISOR, default 5, the divisor; legal range 2..255.
REQ-002 The block SHALL have parameter CNT_W, default 8, the bit-counter width; legal range 2..16.
REQ-003 The block SHALL derive local width RW = $clog2(DIVISOR), with a minimum of 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 valid  input  1  new_bit is presented this cycle and is consumed.
REQ-007 new_bit  input  1  next bit of the number.
REQ-008 start  input  1  discards the current number; the next bit begins a new number.
REQ-009 lsb_first  input  1  bit-order select; sampled only when start=1; present only under SERIAL_DIV_LSB_MODE_EN.
REQ-010 remainder  output  RW  current value mod DIVISOR, registered.
REQ-011 div_by_n  output  1  high when remainder==0; decoded combinationally from the register.
REQ-012 bit_count  output  CNT_W  number of bits accepted since the last start or reset; saturating.
REQ-013 count_sat  output  1  high when bit_count equals 2^CNT_W-1.

Function
REQ-014 An accepted bit (valid=1) SHALL be reflected in remainder, div_by_n and bit_count on the next rising edge: 1-cycle latency.
REQ-015 When valid=0 and start=0, all state SHALL hold.
REQ-016 MSB-first update SHALL be: t = 2*remainder + new_bit (RW+1 bits); the next remainder is t-DIVISOR if t>=DIVISOR, else t.
REQ-017 The update SHALL use no divider or modulo operator; one compare and one subtract only.
REQ-018 LSB-first update SHALL be: remainder_next = (remainder + new_bit*weight) mod DIVISOR, and weight_next = (2*weight) mod DIVISOR.
REQ-019 Each LSB-first mod operation SHALL be a single conditional subtract.
REQ-020 The weight register (RW bits) SHALL be 1 after reset or start.
REQ-021 start=1 with valid=0 SHALL clear remainder and bit_count to 0, set weight to 1, and produce div_by_n=1 on the next cycle.
REQ-022 start=1 with valid=1 SHALL treat the prior value as 0 and accept new_bit as the first bit of a new number: remainder=new_bit, bit_count=1.
REQ-023 For start=1 with valid=1 in LSB-first mode, the resulting weight SHALL be 2 mod DIVISOR.
REQ-024 Empty number (bit_count=0): remainder=0 and div_by_n=1.
REQ-025 Saturation: bit_count SHALL stop at 2^CNT_W-1 and count_sat SHALL stay high until start or reset.
REQ-026 The remainder SHALL keep updating after saturation.
REQ-027 A change of lsb_first without start SHALL be ignored; the mode register holds.
REQ-028 remainder SHALL never hold a value >= DIVISOR.

Reset
REQ-029 On rst=1, asynchronously: remainder=0, weight=1, bit_count=0, mode=MSB-first; hence div_by_n=1 and count_sat=0.
REQ-030 Reset mid-number SHALL discard the number.
REQ-031 The first bit accepted after rst deasserts SHALL be the first bit of a new number.

Configuration
REQ-032 With SERIAL_DIV_LSB_MODE_EN defined: lsb_first port, mode register, weight register and LSB-first datapath SHALL be present.
REQ-033 Without SERIAL_DIV_LSB_MODE_EN: no lsb_first port and no weight or mode registers; operation SHALL be MSB-first only and otherwise identical.

Verification
REQ-034 DIVISOR=5, MSB-first, bits 1,0,1,0 -> remainder 1,2,0,0; div_by_n 0,0,1,1; bit_count 1..4.
REQ-035 DIVISOR=3, macro on, start+lsb_first=1, bits 1,1 (value 3) -> remainder 1,0; div_by_n high after bit 2.
REQ-036 DIVISOR=5, bits 1,1 then start+valid with bit 1 -> remainder 1, bit_count 1 (not 7 mod 5 = 2).
REQ-037 CNT_W=3, 9 bits of 1 -> bit_count holds 7, count_sat=1, remainder = (2^9-1) mod DIVISOR.
REQ-038 valid gaps between bits and rst asserted between clock edges -> gaps hold state; reset clears asynchronously with no clock edge; next bit restarts at bit_count=1.
